// File: rtl/spram_rw_arbiter_pkg.sv
// Shared definitions for the single-port SRAM read/write arbiter:
// stall-statistics counter width and the per-cycle SRAM issue selection.
package spram_rw_arbiter_pkg;

   // Width of the optional stall-cycle counter (SPRAM_ARB_STATS_EN builds)
   localparam int STAT_W = 16;

   // Which operation owns the SRAM port in the current cycle
   typedef enum logic [1:0] {
      ISSUE_IDLE  = 2'd0,
      ISSUE_READ  = 2'd1,
      ISSUE_WRITE = 2'd2
   } issue_sel_e;

endpackage

// File: rtl/spram_arb_wbuf.sv
// Write buffer for the SRAM arbiter: a small FIFO of (addr, data, byte mask)
// entries with a parallel compare of every occupied entry against a lookup
// address, used to hold back reads that would overtake a pending write.
module spram_arb_wbuf #(
   parameter int DW         = 32,
   parameter int AW         = 10,
   parameter int WBUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic [AW-1:0]   push_addr,
   input  logic [DW-1:0]   push_data,
   input  logic [DW/8-1:0] push_mask,
   input  logic            pop,
   input  logic [AW-1:0]   cmp_addr,
   output logic            full,
   output logic            empty,
   output logic            hit,
   output logic [AW-1:0]   head_addr,
   output logic [DW-1:0]   head_data,
   output logic [DW/8-1:0] head_mask
);

   localparam int PW = $clog2(WBUF_DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic [WBUF_DEPTH-1:0] vld;

   logic [AW-1:0]   addr_q [WBUF_DEPTH];
   logic [DW-1:0]   data_q [WBUF_DEPTH];
   logic [DW/8-1:0] mask_q [WBUF_DEPTH];

   // Pointers, occupancy and per-entry valid bits; pointers wrap naturally
   // because the depth is a power of two. Push only when not full and pop
   // only when not empty, so push and pop never target the same slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         vld    <= '0;
      end else begin
         if (push) begin
            wr_ptr      <= wr_ptr + 1'b1;
            vld[wr_ptr] <= 1'b1;
         end
         if (pop) begin
            rd_ptr      <= rd_ptr + 1'b1;
            vld[rd_ptr] <= 1'b0;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Entry payload storage; contents are only meaningful while vld is set
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr] <= push_addr;
         data_q[wr_ptr] <= push_data;
         mask_q[wr_ptr] <= push_mask;
      end
   end

   // Compare the lookup address against every occupied entry
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
         if (vld[i] && (addr_q[i] == cmp_addr)) hit = 1'b1;
      end
   end

   assign full      = (count == CW'(WBUF_DEPTH));
   assign empty     = (count == '0);
   assign head_addr = addr_q[rd_ptr];
   assign head_data = data_q[rd_ptr];
   assign head_mask = mask_q[rd_ptr];

endmodule

// File: rtl/spram_rw_arbiter.sv
// Read/write arbiter in front of a single-port SRAM with 1-cycle read
// latency. Reads issue combinationally in their accept cycle and win the
// port; writes are buffered and drain from the FIFO head when no read is
// accepted. Reads to addresses still pending in the buffer are held off.
// Optional build macro SPRAM_ARB_STATS_EN adds the stat_stall output, a
// saturating count of cycles in which a read request was stalled.
module spram_rw_arbiter
   import spram_rw_arbiter_pkg::*;
#(
   parameter int DW         = 32,
   parameter int AW         = 10,
   parameter int WBUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wr_valid,
   output logic            wr_ready,
   input  logic [AW-1:0]   wr_addr,
   input  logic [DW-1:0]   wr_data,
   input  logic [DW/8-1:0] wr_mask,
   input  logic            rd_valid,
   output logic            rd_ready,
   input  logic [AW-1:0]   rd_addr,
   output logic            rd_rvalid,
   output logic [DW-1:0]   rd_rdata,
   output logic            mem_ce,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_din,
   output logic [DW-1:0]   mem_wmask,
   input  logic [DW-1:0]   mem_dout
`ifdef SPRAM_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_stall
`endif
);

   logic            buf_full;
   logic            buf_empty;
   logic            buf_hit;
   logic [AW-1:0]   head_addr;
   logic [DW-1:0]   head_data;
   logic [DW/8-1:0] head_mask;
   logic            wr_fire;
   logic            rd_fire;
   logic            rvld_q;
   issue_sel_e      sel;

   // A full buffer must drain first; a pending write to rd_addr must land
   // before the read may see the array. A write accepted in the same cycle
   // is not yet stored, so it naturally orders after the read.
   assign wr_ready = !buf_full;
   assign rd_ready = !buf_full && !buf_hit;
   assign wr_fire  = wr_valid && wr_ready;
   assign rd_fire  = rd_valid && rd_ready;

   spram_arb_wbuf #(
      .DW        (DW),
      .AW        (AW),
      .WBUF_DEPTH(WBUF_DEPTH)
   ) u_wbuf (
      .clk      (clk),
      .reset    (reset),
      .push     (wr_fire),
      .push_addr(wr_addr),
      .push_data(wr_data),
      .push_mask(wr_mask),
      .pop      (sel == ISSUE_WRITE),
      .cmp_addr (rd_addr),
      .full     (buf_full),
      .empty    (buf_empty),
      .hit      (buf_hit),
      .head_addr(head_addr),
      .head_data(head_data),
      .head_mask(head_mask)
   );

   // Pick this cycle's SRAM operation: read first, then buffered write
   always_comb begin
      sel = ISSUE_IDLE;
      if (reset)           sel = ISSUE_IDLE;
      else if (rd_fire)    sel = ISSUE_READ;
      else if (!buf_empty) sel = ISSUE_WRITE;
   end

   // Drive the SRAM port from the selected operation; byte mask to bit mask
   always_comb begin
      mem_ce   = (sel != ISSUE_IDLE);
      mem_we   = (sel == ISSUE_WRITE);
      mem_addr = (sel == ISSUE_READ) ? rd_addr : head_addr;
      mem_din  = head_data;
      for (int i = 0; i < DW; i++) begin
         mem_wmask[i] = head_mask[i/8];
      end
   end

   // Read response strobe follows the issue by exactly one cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rvld_q <= 1'b0;
      else       rvld_q <= (sel == ISSUE_READ);
   end

   assign rd_rvalid = rvld_q;
   assign rd_rdata  = mem_dout;

`ifdef SPRAM_ARB_STATS_EN
   // Saturating count of cycles where a read request was held off
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_stall <= '0;
      end else if (rd_valid && !rd_ready && (stat_stall != {STAT_W{1'b1}})) begin
         stat_stall <= stat_stall + 1'b1;
      end
   end
`else
   // Stall statistics are not built in this configuration
`endif

endmodule

// File: tb/tb_spram_rw_arbiter.sv
// Directed bench for spram_rw_arbiter with a behavioural single-port SRAM.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_spram_rw_arbiter;

   localparam int DW = 32;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [3:0]    wr_mask = '0;
   logic          rd_valid = 1'b0;
   logic          rd_ready;
   logic [AW-1:0] rd_addr = '0;
   logic          rd_rvalid;
   logic [DW-1:0] rd_rdata;
   logic          mem_ce;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_wmask;
   logic [DW-1:0] mem_dout = '0;
`ifdef SPRAM_ARB_STATS_EN
   logic [15:0]   stat_stall;
`endif

   logic [DW-1:0] sram [0:(1<<AW)-1];
   int            wr_count = 0;
   int            errors = 0;
   int            checks = 0;
   int            wc_snap;

   always #5 clk = ~clk;

   spram_rw_arbiter #(.DW(DW), .AW(AW), .WBUF_DEPTH(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_mask  (wr_mask),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .rd_addr  (rd_addr),
      .rd_rvalid(rd_rvalid),
      .rd_rdata (rd_rdata),
      .mem_ce   (mem_ce),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_wmask(mem_wmask),
      .mem_dout (mem_dout)
`ifdef SPRAM_ARB_STATS_EN
      ,
      .stat_stall(stat_stall)
`endif
   );

   // Behavioural single-port SRAM: bit-masked write, 1-cycle read
   always @(posedge clk) begin
      if (mem_ce && mem_we) begin
         sram[mem_addr] <= (sram[mem_addr] & ~mem_wmask) | (mem_din & mem_wmask);
         wr_count <= wr_count + 1;
      end
      if (mem_ce && !mem_we) mem_dout <= sram[mem_addr];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_wr(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] m);
      wr_valid = v; wr_addr = a; wr_data = d; wr_mask = m;
   endtask

   task automatic drive_rd(input logic v, input logic [AW-1:0] a);
      rd_valid = v; rd_addr = a;
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) sram[i] = '0;

      // Reset state, with a read request present
      @(negedge clk); drive_rd(1'b1, 10'd3); #1;
      chk("rst_wr_ready", wr_ready, 1'b1);
      chk("rst_rd_ready", rd_ready, 1'b1);
      chk("rst_mem_ce", mem_ce, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_rvalid", rd_rvalid, 1'b0);
      @(negedge clk); reset = 1'b0; drive_rd(1'b0, 10'd0); #1;
      chk("idle_mem_ce", mem_ce, 1'b0);

      // Write A5A5A5A5 to 3, drain, read back
      @(negedge clk); drive_wr(1'b1, 10'd3, 32'hA5A5A5A5, 4'hF); #1;
      chk("t1_wr_ready", wr_ready, 1'b1);
      chk("t1_no_early_write", mem_ce, 1'b0);
      @(negedge clk); drive_wr(1'b0, 10'd0, 32'h0, 4'h0); #1;
      chk("t1_drain_we", mem_we, 1'b1);
      chk("t1_drain_addr", mem_addr, 10'd3);
      chk("t1_drain_din", mem_din, 32'hA5A5A5A5);
      chk("t1_drain_wmask", mem_wmask, 32'hFFFFFFFF);
      @(negedge clk); drive_rd(1'b1, 10'd3); #1;
      chk("t1_rd_ready", rd_ready, 1'b1);
      chk("t1_rd_ce", mem_ce, 1'b1);
      chk("t1_rd_we", mem_we, 1'b0);
      chk("t1_rd_addr", mem_addr, 10'd3);
      @(negedge clk); drive_rd(1'b0, 10'd0); #1;
      chk("t1_rvalid", rd_rvalid, 1'b1);
      chk("t1_rdata", rd_rdata, 32'hA5A5A5A5);
      @(negedge clk); #1;
      chk("t1_rvalid_single", rd_rvalid, 1'b0);

      // RAW hazard: write 7 then read 7 the next cycle
      @(negedge clk); drive_wr(1'b1, 10'd7, 32'h12345678, 4'hF); #1;
      @(negedge clk); drive_wr(1'b0, 10'd0, 32'h0, 4'h0); drive_rd(1'b1, 10'd7); #1;
      chk("t2_hazard_rd_ready", rd_ready, 1'b0);
      chk("t2_hazard_drain", mem_we, 1'b1);
      @(negedge clk); #1;
      chk("t2_rd_ready_after", rd_ready, 1'b1);
      chk("t2_rd_issue", {mem_ce, mem_we}, 2'b10);
      @(negedge clk); drive_rd(1'b0, 10'd0); #1;
      chk("t2_rvalid", rd_rvalid, 1'b1);
      chk("t2_rdata_new", rd_rdata, 32'h12345678);

      // Fill the buffer under continuous reads, then forced drain
      @(negedge clk); drive_wr(1'b1, 10'h10, 32'hD0D0D0D0, 4'hF); drive_rd(1'b1, 10'h20); #1;
      chk("t3_a_read_issue", {mem_ce, mem_we}, 2'b10);
      @(negedge clk); drive_wr(1'b1, 10'h11, 32'hD1D1D1D1, 4'hF); drive_rd(1'b1, 10'h21); #1;
      chk("t3_b_read_issue", {mem_ce, mem_we, mem_addr}, {2'b10, 10'h21});
      chk("t3_b_rvalid", rd_rvalid, 1'b1);
      @(negedge clk); drive_wr(1'b1, 10'h12, 32'hD2D2D2D2, 4'hF); drive_rd(1'b1, 10'h22); #1;
      chk("t3_full_wr_ready", wr_ready, 1'b0);
      chk("t3_full_rd_ready", rd_ready, 1'b0);
      chk("t3_forced_drain", {mem_we, mem_addr}, {1'b1, 10'h10});
      @(negedge clk); #1;
      chk("t3_d_wr_ready", wr_ready, 1'b1);
      chk("t3_d_rd_ready", rd_ready, 1'b1);
      chk("t3_d_read_issue", {mem_ce, mem_we, mem_addr}, {2'b10, 10'h22});
      @(negedge clk); drive_wr(1'b0, 10'd0, 32'h0, 4'h0); drive_rd(1'b0, 10'd0); #1;
      chk("t3_e_rvalid", rd_rvalid, 1'b1);
      chk("t3_e_drain", {mem_we, mem_addr, mem_din}, {1'b1, 10'h11, 32'hD1D1D1D1});
      @(negedge clk); #1;
      chk("t3_f_drain_wrap", {mem_we, mem_addr, mem_din}, {1'b1, 10'h12, 32'hD2D2D2D2});
      @(negedge clk); #1;
      chk("t3_g_empty", mem_ce, 1'b0);
      chk("t3_sram_10", sram[10'h10], 32'hD0D0D0D0);

      // Byte-masked write over existing data
      @(negedge clk); drive_wr(1'b1, 10'd5, 32'h11223344, 4'hF); #1;
      @(negedge clk); drive_wr(1'b1, 10'd5, 32'h0000FF00, 4'h2); #1;
      chk("t4_full_mask", mem_wmask, 32'hFFFFFFFF);
      @(negedge clk); drive_wr(1'b0, 10'd0, 32'h0, 4'h0); #1;
      chk("t4_byte_wmask", mem_wmask, 32'h0000FF00);
      chk("t4_byte_din", mem_din, 32'h0000FF00);
      @(negedge clk); drive_rd(1'b1, 10'd5); #1;
      chk("t4_rd_ready", rd_ready, 1'b1);
      @(negedge clk); drive_rd(1'b0, 10'd0); #1;
      chk("t4_rdata_merged", rd_rdata, 32'h1122FF44);

      // Reset right after a read issue with one write buffered
      @(negedge clk); drive_wr(1'b1, 10'd9, 32'hDEADBEEF, 4'hF); drive_rd(1'b1, 10'd3); #1;
      chk("t5_read_issue", {mem_ce, mem_we}, 2'b10);
      wc_snap = wr_count;
      @(posedge clk); #1;
      reset = 1'b1; drive_wr(1'b0, 10'd0, 32'h0, 4'h0); drive_rd(1'b0, 10'd0);
      @(negedge clk); #1;
      chk("t5_rvalid", rd_rvalid, 1'b0);
      chk("t5_wr_ready", wr_ready, 1'b1);
      chk("t5_mem_ce", mem_ce, 1'b0);
      @(negedge clk); reset = 1'b0; #1;
      chk("t5_post_ce", mem_ce, 1'b0);
      chk("t5_post_rvalid", rd_rvalid, 1'b0);
      repeat (3) @(negedge clk); #1;
      chk("t5_no_write", wr_count, wc_snap);
      chk("t5_sram_9", sram[9], 32'h0);

`ifdef SPRAM_ARB_STATS_EN
      chk("t6_stat_rst", stat_stall, 16'h0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); drive_wr(1'b1, 10'h30, 32'(k), 4'hF); drive_rd(1'b0, 10'd0);
         @(negedge clk); drive_wr(1'b0, 10'd0, 32'h0, 4'h0); drive_rd(1'b1, 10'h30);
         @(negedge clk); drive_rd(1'b0, 10'd0);
      end
      #1;
      chk("t6_stat_5", stat_stall, 16'd5);
      @(negedge clk); drive_wr(1'b1, 10'h31, 32'h1, 4'hF); drive_rd(1'b1, 10'h31);
      repeat (70000) @(negedge clk);
      drive_wr(1'b0, 10'd0, 32'h0, 4'h0); drive_rd(1'b0, 10'd0); #1;
      chk("t6_stat_sat", stat_stall, 16'hFFFF);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
